// File: rtl/seg_tdm_capture.sv
// Recovers digit values from a multiplexed active-low seven-segment bus and publishes BCD frames.
// Define SEG_CAPTURE_HEX_EN to also decode the hex letters A..F.
module seg_tdm_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg,
    input  logic [NUM_DIGITS-1:0]     an,
    input  logic                      err_clr,
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic [NUM_DIGITS-1:0]     blank,
    output logic [NUM_DIGITS-1:0]     invalid,
    output logic                      frame_valid,
    output logic                      err
);

    localparam int unsigned CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    // Decoded pattern: {invalid, blank, value[3:0]}
    function automatic logic [5:0] f_decode(input logic [6:0] p);
        logic [5:0] d;
        d = {2'b10, 4'h0};
        case (p)
            7'b1000000: d = {2'b00, 4'h0};
            7'b1111001: d = {2'b00, 4'h1};
            7'b0100100: d = {2'b00, 4'h2};
            7'b0110000: d = {2'b00, 4'h3};
            7'b0011001: d = {2'b00, 4'h4};
            7'b0010010: d = {2'b00, 4'h5};
            7'b0000010: d = {2'b00, 4'h6};
            7'b1111000: d = {2'b00, 4'h7};
            7'b0000000: d = {2'b00, 4'h8};
            7'b0010000: d = {2'b00, 4'h9};
            7'b1111111: d = {2'b01, 4'h0};
`ifdef SEG_CAPTURE_HEX_EN
            7'b0001000: d = {2'b00, 4'hA};
            7'b0000011: d = {2'b00, 4'hB};
            7'b1000110: d = {2'b00, 4'hC};
            7'b0100001: d = {2'b00, 4'hD};
            7'b0000110: d = {2'b00, 4'hE};
            7'b0001110: d = {2'b00, 4'hF};
`endif
            default:    d = {2'b10, 4'h0};
        endcase
        return d;
    endfunction

    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg_prev;
    logic [NUM_DIGITS-1:0] r_an_prev;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_slot_done;
    logic [NUM_DIGITS-1:0] r_seen;
    logic [BCD_W-1:0]      r_sh_bcd;
    logic [NUM_DIGITS-1:0] r_sh_blank;
    logic [NUM_DIGITS-1:0] r_sh_inv;
    logic [BCD_W-1:0]      r_bcd;
    logic [NUM_DIGITS-1:0] r_blank;
    logic [NUM_DIGITS-1:0] r_invalid;
    logic                  r_frame_valid;
    logic                  r_err;

    logic                  w_same;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [NUM_DIGITS-1:0] w_sel;
    logic                  w_slot_ok;
    logic                  w_capture;
    logic                  w_seen_all;
    logic [5:0]            w_dec;

    // Input sample stage plus one-deep history for the stability compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg      <= '0;
            r_an       <= '0;
            r_seg_prev <= '0;
            r_an_prev  <= '0;
        end else begin
            r_seg      <= seg;
            r_an       <= an;
            r_seg_prev <= r_seg;
            r_an_prev  <= r_an;
        end
    end

    always_comb begin
        w_same     = (r_seg == r_seg_prev) && (r_an == r_an_prev);
        w_cnt_nxt  = CNT_W'(1);
        if (w_same) begin
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end
        w_sel      = ~r_an;
        w_slot_ok  = $onehot(w_sel);
        w_capture  = w_same && (w_cnt_nxt == CNT_MAX) && w_slot_ok && !r_slot_done;
        w_seen_all = &r_seen;
        w_dec      = f_decode(r_seg);
    end

    // Stability counter and one-capture-per-slot guard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_slot_done <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (!w_same) begin
                r_slot_done <= 1'b0;
            end else if (w_capture) begin
                r_slot_done <= 1'b1;
            end
        end
    end

    // Shadow frame and seen mask; seen clears on the publish edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_bcd   <= '0;
            r_sh_blank <= '0;
            r_sh_inv   <= '0;
            r_seen     <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (w_capture && w_sel[i]) begin
                    r_sh_bcd[4*i +: 4] <= w_dec[3:0];
                    r_sh_blank[i]      <= w_dec[4];
                    r_sh_inv[i]        <= w_dec[5];
                end
            end
            r_seen <= (w_seen_all ? '0 : r_seen) | (w_capture ? w_sel : '0);
        end
    end

    // Publish stage; err set takes priority over err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd         <= '0;
            r_blank       <= '0;
            r_invalid     <= '0;
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_frame_valid <= w_seen_all;
            if (w_seen_all) begin
                r_bcd     <= r_sh_bcd;
                r_blank   <= r_sh_blank;
                r_invalid <= r_sh_inv;
            end
            if (w_seen_all && (|r_sh_inv)) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bcd         = r_bcd;
    assign blank       = r_blank;
    assign invalid     = r_invalid;
    assign frame_valid = r_frame_valid;
    assign err         = r_err;

endmodule

// File: tb/tb_seg_tdm_capture.sv
// Directed bench for seg_tdm_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seg_tdm_capture;

    localparam logic [6:0] P0   = 7'b1000000;
    localparam logic [6:0] P1   = 7'b1111001;
    localparam logic [6:0] P2   = 7'b0100100;
    localparam logic [6:0] P3   = 7'b0110000;
    localparam logic [6:0] P4   = 7'b0011001;
    localparam logic [6:0] P5   = 7'b0010010;
    localparam logic [6:0] P6   = 7'b0000010;
    localparam logic [6:0] P7   = 7'b1111000;
    localparam logic [6:0] P8   = 7'b0000000;
    localparam logic [6:0] P9   = 7'b0010000;
    localparam logic [6:0] PBLK = 7'b1111111;
    localparam logic [6:0] PINV = 7'b0101010;
    localparam logic [6:0] PF   = 7'b0001110;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err_clr;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [3:0]  invalid;
    logic        frame_valid;
    logic        err;

    int n_assert;
    int n_fail;
    int fv_cnt;
    int fv_base;

    seg_tdm_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .err_clr     (err_clr),
        .bcd         (bcd),
        .blank       (blank),
        .invalid     (invalid),
        .frame_valid (frame_valid),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one slot and hold it for n falling edges
    task automatic show(input int slot, input logic [6:0] pat, input int n);
        logic [3:0] a;
        a = 4'hF;
        a[slot] = 1'b0;
        an  = a;
        seg = pat;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        fv_cnt   = 0;
        rst_n    = 1'b0;
        err_clr  = 1'b0;
        an       = 4'hF;
        seg      = PBLK;
        repeat (3) @(negedge clk);
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_blank", 32'(blank), 32'h0);
        chk("reset_invalid", 32'(invalid), 32'h0);
        chk("reset_fv", 32'(frame_valid), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic scan 1,2,3,4 with latency check on the final digit
        fv_base = fv_cnt;
        show(0, P1, 10);
        show(1, P2, 10);
        show(2, P3, 10);
        show(3, P4, 5);
        chk("basic_fv_early", 32'(frame_valid), 32'h0);
        @(negedge clk);
        chk("basic_fv_pulse", 32'(frame_valid), 32'h1);
        chk("basic_bcd", 32'(bcd), 32'h4321);
        chk("basic_blank", 32'(blank), 32'h0);
        chk("basic_invalid", 32'(invalid), 32'h0);
        chk("basic_err", 32'(err), 32'h0);
        @(negedge clk);
        chk("basic_fv_drop", 32'(frame_valid), 32'h0);
        repeat (3) @(negedge clk);
        chk("basic_fv_count", 32'(fv_cnt - fv_base), 32'h1);
        chk("basic_hold_bcd", 32'(bcd), 32'h4321);

        // Glitch: a 3-cycle 7 on slot 2 must not be captured
        fv_base = fv_cnt;
        show(0, P1, 10);
        show(1, P2, 10);
        show(2, P7, 3);
        show(2, P9, 10);
        show(3, P4, 10);
        chk("glitch_fv_count", 32'(fv_cnt - fv_base), 32'h1);
        chk("glitch_bcd", 32'(bcd), 32'h4921);

        // Blank and invalid; err_clr coincides with publish so set wins
        show(0, P5, 10);
        show(1, PINV, 10);
        show(2, P5, 10);
        show(3, PBLK, 5);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("bi_fv_pulse", 32'(frame_valid), 32'h1);
        chk("bi_bcd", 32'(bcd), 32'h0505);
        chk("bi_blank", 32'(blank), 32'h8);
        chk("bi_invalid", 32'(invalid), 32'h2);
        chk("bi_err_set_wins", 32'(err), 32'h1);
        @(negedge clk);
        chk("bi_err_sticky", 32'(err), 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("bi_err_cleared", 32'(err), 32'h0);
        show(0, P1, 10);
        show(1, P2, 10);
        show(2, P3, 10);
        show(3, P4, 10);
        chk("clean_err", 32'(err), 32'h0);
        chk("clean_invalid", 32'(invalid), 32'h0);
        chk("clean_blank", 32'(blank), 32'h0);

        // Ghosting: multi-low and all-high anodes never capture
        fv_base = fv_cnt;
        an = 4'h0; seg = P1;
        repeat (20) @(negedge clk);
        an = 4'hF;
        repeat (20) @(negedge clk);
        show(1, P6, 10);
        show(2, P7, 10);
        show(3, P8, 10);
        chk("ghost_no_frame", 32'(fv_cnt - fv_base), 32'h0);
        show(0, P9, 50);
        chk("ghost_one_frame", 32'(fv_cnt - fv_base), 32'h1);
        chk("ghost_bcd", 32'(bcd), 32'h8769);
        fv_base = fv_cnt;
        show(1, P1, 10);
        show(2, P2, 10);
        show(3, P3, 10);
        chk("long_hold_single_capture", 32'(fv_cnt - fv_base), 32'h0);
        show(0, P0, 10);
        chk("long_hold_next_frame", 32'(fv_cnt - fv_base), 32'h1);
        chk("long_hold_bcd", 32'(bcd), 32'h3210);

        // Mid-frame reset discards the partial frame
        show(0, P1, 10);
        show(1, P2, 10);
        rst_n = 1'b0;
        #1;
        chk("midrst_bcd", 32'(bcd), 32'h0);
        chk("midrst_fv", 32'(frame_valid), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        fv_base = fv_cnt;
        show(2, P5, 10);
        show(3, P1, 10);
        chk("midrst_no_frame", 32'(fv_cnt - fv_base), 32'h0);
        show(0, PF, 10);
        show(1, P2, 10);
        chk("midrst_new_frame", 32'(fv_cnt - fv_base), 32'h1);
`ifdef SEG_CAPTURE_HEX_EN
        chk("hex_bcd", 32'(bcd), 32'h152F);
        chk("hex_invalid", 32'(invalid), 32'h0);
        chk("hex_err", 32'(err), 32'h0);
`else
        chk("hex_bcd", 32'(bcd), 32'h1520);
        chk("hex_invalid", 32'(invalid), 32'h1);
        chk("hex_err", 32'(err), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
